// File: rtl/dot_accumulator_if.sv
// Handshake bundle between an AdderTree stage and dot_accumulator.
//   in_data/in_valid/in_ready    : partial-sum beats into the accumulator
//   out_data/out_sat/out_valid/out_ready : requantized result out of it
// slave  : the accumulator side (consumes beats, produces results)
// master : the environment side (produces beats, consumes results)
interface dot_accumulator_if #(
  parameter int InWidth  = 8,
  parameter int OutWidth = 8
);
  logic [InWidth-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic [OutWidth-1:0] out_data;
  logic                out_sat;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums Chunks consecutive signed partial sums from an
// AdderTree, arithmetic-shifts the total right by Shift, saturates it to
// OutWidth and offers it on a valid/ready handshake.
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : slave modport of dot_accumulator_if
//            in_data (signed InWidth), in_valid, in_ready
//            out_data (signed OutWidth), out_sat, out_valid, out_ready
module dot_accumulator #(
  parameter int InWidth  = 8,
  parameter int Chunks   = 4,
  parameter int Shift    = 0,
  parameter int OutWidth = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  dot_accumulator_if.slave     bus
);
  localparam int AccWidth = InWidth + $clog2(Chunks) + 1;
  localparam int CntWidth = $clog2(Chunks);
  // Clip comparison runs at whichever is wider so nothing is truncated first.
  localparam int CmpWidth = (AccWidth > OutWidth) ? AccWidth : OutWidth;

  localparam logic signed [CmpWidth-1:0] MaxOut =
    {{(CmpWidth-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [CmpWidth-1:0] MinOut =
    {{(CmpWidth-OutWidth+1){1'b1}}, {(OutWidth-1){1'b0}}};
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Chunks - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                     state_q, state_d;
  logic signed [AccWidth-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]        count_q, count_d;
  logic [OutWidth-1:0]        out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [AccWidth-1:0] total;
  logic signed [AccWidth-1:0] shifted;
  logic signed [CmpWidth-1:0] wide;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  always_comb begin
    total      = acc_q + AccWidth'(signed'(bus.in_data));
    shifted    = total >>> Shift;
    wide       = CmpWidth'(shifted);
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          if (count_q == LastBeat) begin
            if (wide > MaxOut) begin
              out_data_d = MaxOut[OutWidth-1:0];
              out_sat_d  = 1'b1;
            end else if (wide < MinOut) begin
              out_data_d = MinOut[OutWidth-1:0];
              out_sat_d  = 1'b1;
            end else begin
              out_data_d = wide[OutWidth-1:0];
              out_sat_d  = 1'b0;
            end
            acc_d   = '0;
            count_d = '0;
            state_d = EMIT;
          end else begin
            acc_d   = total;
            count_d = count_q + CntWidth'(1);
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Handshake flags depend on the registered state only.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule
